// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences the six march elements over one memory port,
// compares read data the cycle after each read and records the first failing address.
module mbist_march_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH:0]   fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    // state | meaning
    // IDLE  | waiting for start          W0 | M0 fill with zeros
    // RW    | M1..M4 read then write     R0 | M5 final read of zeros
    // DONE  | result held until start or rst
    typedef enum logic [2:0] {S_IDLE, S_W0, S_RW, S_R0, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_MAX   = '1;
    localparam logic PH_READ   = 1'b0;
    localparam logic PH_SECOND = 1'b1;

    state_t                r_state, w_state;
    logic                  r_phase, w_phase;
    logic [2:0]            r_elem, w_elem;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic                  r_fail, w_fail;
    logic [ADDR_WIDTH:0]   r_fail_count, w_fail_count;
    logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr;

    logic                  w_down;
    logic                  w_elem_last;
    logic                  w_check;
    logic                  w_mismatch;
    logic [DATA_WIDTH-1:0] w_exp_rd;

    // M1/M3 expect zeros and write ones; M2/M4 the reverse
    assign w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_elem_last = w_down ? (r_addr == '0) : (r_addr == LAST_ADDR);
    assign w_check     = (r_phase == PH_SECOND) && ((r_state == S_RW) || (r_state == S_R0));
    assign w_exp_rd    = (r_state == S_RW) ? {DATA_WIDTH{~r_elem[0]}} : '0;
    assign w_mismatch  = w_check && (mem_rdata != w_exp_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= PH_READ;
            r_elem       <= 3'd0;
            r_addr       <= '0;
            r_fail       <= 1'b0;
            r_fail_count <= '0;
            r_fail_addr  <= '0;
        end else begin
            r_state      <= w_state;
            r_phase      <= w_phase;
            r_elem       <= w_elem;
            r_addr       <= w_addr;
            r_fail       <= w_fail;
            r_fail_count <= w_fail_count;
            r_fail_addr  <= w_fail_addr;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_phase      = r_phase;
        w_elem       = r_elem;
        w_addr       = r_addr;
        w_fail       = r_fail;
        w_fail_count = r_fail_count;
        w_fail_addr  = r_fail_addr;

        if (w_mismatch) begin
            w_fail = 1'b1;
            if (r_fail_count != CNT_MAX) begin
                w_fail_count = r_fail_count + (ADDR_WIDTH+1)'(1);
            end
            if (!r_fail) begin
                w_fail_addr = r_addr;
            end
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state      = S_W0;
                    w_phase      = PH_READ;
                    w_elem       = 3'd0;
                    w_addr       = '0;
                    w_fail       = 1'b0;
                    w_fail_count = '0;
                    w_fail_addr  = '0;
                end
            end
            S_W0: begin
                if (r_addr == LAST_ADDR) begin
                    w_state = S_RW;
                    w_elem  = 3'd1;
                    w_phase = PH_READ;
                    w_addr  = '0;
                end else begin
                    w_addr = r_addr + ADDR_WIDTH'(1);
                end
            end
            S_RW: begin
                if (r_phase == PH_READ) begin
                    w_phase = PH_SECOND;
                end else begin
                    w_phase = PH_READ;
                    if (w_elem_last) begin
                        if (r_elem == 3'd4) begin
                            w_state = S_R0;
                            w_addr  = '0;
                        end else begin
                            w_elem = r_elem + 3'd1;
                            // M3 and M4 both walk down, M2 starts upward
                            w_addr = (r_elem == 3'd1) ? '0 : LAST_ADDR;
                        end
                    end else begin
                        w_addr = w_down ? (r_addr - ADDR_WIDTH'(1)) : (r_addr + ADDR_WIDTH'(1));
                    end
                end
            end
            S_R0: begin
                if (r_phase == PH_READ) begin
                    w_phase = PH_SECOND;
                end else begin
                    w_phase = PH_READ;
                    if (r_addr == LAST_ADDR) begin
                        w_state = S_DONE;
                    end else begin
                        w_addr = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_W0: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_addr;
                busy     = 1'b1;
            end
            S_RW: begin
                mem_en    = 1'b1;
                mem_we    = r_phase;
                mem_addr  = r_addr;
                mem_wdata = r_phase ? {DATA_WIDTH{r_elem[0]}} : '0;
                busy      = 1'b1;
            end
            S_R0: begin
                mem_en   = ~r_phase;
                mem_addr = r_addr;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign fail       = r_fail;
    assign fail_count = r_fail_count;
    assign fail_addr  = r_fail_addr;

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-003 SHALL have parameter MEM_SIZE, default 32, number of words tested (addresses 0..MEM_SIZE-1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  run request, sampled each cycle.
REQ-007 SHALL have port mem_en  output  1  memory access enable.
REQ-008 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  access address.
REQ-010 SHALL have port mem_wdata  output  DATA_WIDTH  write data.
REQ-011 SHALL have port mem_rdata  input  DATA_WIDTH  read data, valid the cycle after a read is issued.
REQ-012 SHALL have port busy  output  1  test in progress.
REQ-013 SHALL have port done  output  1  test complete, level.
REQ-014 SHALL have port fail  output  1  sticky: at least one mismatch this run.
REQ-015 SHALL have port fail_count  output  ADDR_WIDTH+1  number of mismatching reads, saturating.
REQ-016 SHALL have port fail_addr  output  ADDR_WIDTH  address of first mismatch this run.

Function
REQ-017 SHALL run March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0); data 0 = all zeros, 1 = all ones.
REQ-018 SHALL use states IDLE, W0, RW, R0, DONE; RW and R0 carry a phase bit (READ/SECOND) and an element index 1..4.
REQ-019 SHALL, in IDLE or DONE with start=1, clear fail, fail_count, fail_addr, done, and enter W0 at address 0 on the next cycle.
REQ-020 SHALL, in W0, issue one write per cycle (mem_en=1, mem_we=1, mem_wdata=0), addresses 0..MEM_SIZE-1 ascending.
REQ-021 SHALL, in RW, spend 2 cycles per address: READ phase issues a read; SECOND phase issues the write of the element's new data and compares mem_rdata with expected data.
REQ-022 SHALL, in R0, spend 2 cycles per address: READ phase issues a read; SECOND phase drives mem_en=0 and compares mem_rdata with 0.
REQ-023 SHALL step addresses ascending for M1, M2, M5 and descending MEM_SIZE-1..0 for M3, M4; no address outside 0..MEM_SIZE-1 is ever driven.
REQ-024 SHALL move to the next element directly after the last address of the current element, with no idle cycle; total run = MEM_SIZE + 10*MEM_SIZE cycles (352 at default).
REQ-025 SHALL, on a mismatch, set fail=1, increment fail_count (hold at 2^(ADDR_WIDTH+1)-1), and load fail_addr only if fail was 0.
REQ-026 SHALL drive busy=1 in W0, RW and R0, 0 otherwise; done=1 in DONE only.
REQ-027 SHALL enter DONE the cycle after the last R0 compare; done, fail, fail_count, fail_addr held until start or rst.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 in IDLE and DONE.

Reset
REQ-030 SHALL, with rst=1 at a rising edge, go to IDLE and set all outputs to 0, mem_* included, regardless of state; rst overrides start.
REQ-031 SHALL, on reset mid-run, abandon the test with no further memory access; the next start begins a full run from W0.

Verification
REQ-032 Fault-free memory, start pulse 1 cycle -> busy=1 for 352 cycles, then done=1, fail=0, fail_count=0.
REQ-033 Trace check -> cycles 0..31 write 0x00 to addr 0..31; cycle 32 read addr 0; cycle 33 write 0xFF addr 0; first M3 read at addr 31.
REQ-034 mem_rdata bit0 stuck at 1 for addr 5 -> done=1, fail=1, fail_addr=5, fail_count=3 (M1, M3, M5 reads).
REQ-035 rst=1 at run cycle 100 -> next cycle busy=0, mem_en=0, done=0; a new start completes in 352 cycles.
REQ-036 start held high during the whole run -> ignored while busy; completion at cycle 352; a start seen in DONE clears fail and fail_count and restarts.
